// File: rtl/lockstep_pkg.sv
// Shared types and helpers for the lockstep golden-vs-check comparator.
package lockstep_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lockstep_chan.sv
// One compared channel: masked bus compare, registered mismatch flag and
// saturating mismatch counter.
module lockstep_chan #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             sample,
    input  logic [WIDTH-1:0] golden,
    input  logic [WIDTH-1:0] check,
    input  logic             mask,
    output logic             mismatch_c,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count
);

    logic             mismatch_d, mismatch_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign mismatch_c = !mask && (golden != check);

    always_comb begin
        mismatch_d = mismatch_q;
        cnt_d      = cnt_q;
        if (clear) begin
            mismatch_d = 1'b0;
            cnt_d      = '0;
        end else if (sample) begin
            mismatch_d = mismatch_c;
            if (mismatch_c && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mismatch_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            mismatch_q <= mismatch_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mismatch  = mismatch_q;
    assign err_count = cnt_q;

endmodule

// File: rtl/lockstep_compare.sv
// Lockstep monitor: arms, waits out a settle window, then compares golden vs
// check buses per channel with sticky fail and first-failure capture.
module lockstep_compare
    import lockstep_pkg::*;
#(
    parameter int unsigned CHANNELS     = 3,
    parameter int unsigned WIDTH        = 1,
    parameter int unsigned SETTLE       = 10,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned TS_W         = 16,
    parameter bit          STOP_ON_FAIL = 1'b1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  clock_en,
    input  logic                                  arm,
    input  logic [CHANNELS*WIDTH-1:0]             golden,
    input  logic [CHANNELS*WIDTH-1:0]             check,
    input  logic [CHANNELS-1:0]                   mask,
    output logic [STATE_W-1:0]                    state,
    output logic [CHANNELS-1:0]                   mismatch,
    output logic                                  fail,
    output logic [CHANNELS*CNT_W-1:0]             err_count,
    output logic [clog2_min1(CHANNELS)-1:0]       first_chan,
    output logic [TS_W-1:0]                       first_ts,
    output logic [TS_W-1:0]                       ts
);

    localparam int unsigned FC_W  = clog2_min1(CHANNELS);
    localparam int unsigned SET_W = clog2_min1(SETTLE + 1);

    state_e            state_d, state_q;
    logic [SET_W-1:0]  settle_d, settle_q;
    logic [TS_W-1:0]   ts_d, ts_q;
    logic [TS_W-1:0]   first_ts_d, first_ts_q;
    logic [FC_W-1:0]   first_chan_d, first_chan_q;
    logic              fail_d, fail_q;
    logic              clear_c;
    logic              sample_c;
    logic [CHANNELS-1:0] mm_c;
    logic [FC_W-1:0]   low_idx_c;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        lockstep_chan #(
            .WIDTH (WIDTH),
            .CNT_W (CNT_W)
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .clear      (clear_c),
            .sample     (sample_c),
            .golden     (golden[g*WIDTH +: WIDTH]),
            .check      (check[g*WIDTH +: WIDTH]),
            .mask       (mask[g]),
            .mismatch_c (mm_c[g]),
            .mismatch   (mismatch[g]),
            .err_count  (err_count[g*CNT_W +: CNT_W])
        );
    end

    // Lowest-index mismatching channel wins the first-failure capture.
    always_comb begin
        low_idx_c = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (mm_c[i]) begin
                low_idx_c = FC_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        ts_d         = ts_q;
        fail_d       = fail_q;
        first_ts_d   = first_ts_q;
        first_chan_d = first_chan_q;
        clear_c      = 1'b0;
        sample_c     = 1'b0;
        // Arm deassertion outranks any sample taken on the same cycle.
        if (clock_en) begin
            if (!arm) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        clear_c      = 1'b1;
                        settle_d     = '0;
                        ts_d         = '0;
                        fail_d       = 1'b0;
                        first_ts_d   = '0;
                        first_chan_d = '0;
                        state_d      = (SETTLE == 0) ? ST_COMPARE : ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        settle_d = settle_q + SET_W'(1);
                        if (settle_q == SET_W'(SETTLE - 1)) begin
                            state_d = ST_COMPARE;
                        end
                    end
                    ST_COMPARE: begin
                        sample_c = 1'b1;
                        if (ts_q != {TS_W{1'b1}}) begin
                            ts_d = ts_q + TS_W'(1);
                        end
                        if (|mm_c) begin
                            fail_d = 1'b1;
                            if (!fail_q) begin
                                first_chan_d = low_idx_c;
                                first_ts_d   = ts_q;
                            end
                            if (STOP_ON_FAIL) begin
                                state_d = ST_HALT;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            ts_q         <= '0;
            fail_q       <= 1'b0;
            first_ts_q   <= '0;
            first_chan_q <= '0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            ts_q         <= ts_d;
            fail_q       <= fail_d;
            first_ts_q   <= first_ts_d;
            first_chan_q <= first_chan_d;
        end
    end

    assign state      = state_q;
    assign fail       = fail_q;
    assign ts         = ts_q;
    assign first_ts   = first_ts_q;
    assign first_chan = first_chan_q;

endmodule

// File: tb/tb_lockstep_compare.sv
// Directed bench: a halting instance (SETTLE=10) and a continuous instance
// (SETTLE=4) share stimulus; each task checks the instance it targets.
module tb_lockstep_compare;

    logic        clock;
    logic        reset;
    logic        clock_en;
    logic        arm;
    logic [2:0]  golden;
    logic [2:0]  check;
    logic [2:0]  mask;

    logic [1:0]  s_state, c_state;
    logic [2:0]  s_mm, c_mm;
    logic        s_fail, c_fail;
    logic [23:0] s_err, c_err;
    logic [1:0]  s_fc, c_fc;
    logic [15:0] s_fts, c_fts;
    logic [15:0] s_ts, c_ts;

    int total;
    int bad;

    lockstep_compare #(
        .CHANNELS(3), .WIDTH(1), .SETTLE(10), .CNT_W(8), .TS_W(16), .STOP_ON_FAIL(1'b1)
    ) u_stop (
        .clock(clock), .reset(reset), .clock_en(clock_en), .arm(arm),
        .golden(golden), .check(check), .mask(mask),
        .state(s_state), .mismatch(s_mm), .fail(s_fail), .err_count(s_err),
        .first_chan(s_fc), .first_ts(s_fts), .ts(s_ts)
    );

    lockstep_compare #(
        .CHANNELS(3), .WIDTH(1), .SETTLE(4), .CNT_W(8), .TS_W(16), .STOP_ON_FAIL(1'b0)
    ) u_cont (
        .clock(clock), .reset(reset), .clock_en(clock_en), .arm(arm),
        .golden(golden), .check(check), .mask(mask),
        .state(c_state), .mismatch(c_mm), .fail(c_fail), .err_count(c_err),
        .first_chan(c_fc), .first_ts(c_fts), .ts(c_ts)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        arm      = 1'b0;
        clock_en = 1'b1;
        golden   = 3'b000;
        check    = 3'b000;
        mask     = 3'b000;
        reset    = 1'b1;
        #1;
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (s_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", s_state); end
        total++; if (s_fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%0b exp=0", s_fail); end
        total++; if (s_err !== 24'd0 || c_err !== 24'd0) begin bad++; $display("FAIL reset_err got=%h/%h exp=0", s_err, c_err); end
        total++; if (s_ts !== 16'd0 || s_fts !== 16'd0 || s_fc !== 2'd0 || s_mm !== 3'd0) begin
            bad++; $display("FAIL reset_misc ts=%0d fts=%0d fc=%0d mm=%b exp all 0", s_ts, s_fts, s_fc, s_mm);
        end
    endtask

    task automatic test_clean();
        do_reset();
        arm = 1'b1;
        cyc(1);
        for (int i = 0; i < 50; i++) begin
            golden = 3'($urandom_range(0, 7));
            check  = golden;
            cyc(1);
        end
        total++; if (s_state !== 2'd2) begin bad++; $display("FAIL clean_state got=%0d exp=2", s_state); end
        total++; if (s_fail !== 1'b0) begin bad++; $display("FAIL clean_fail got=%0b exp=0", s_fail); end
        total++; if (s_ts !== 16'd40) begin bad++; $display("FAIL clean_ts got=%0d exp=40", s_ts); end
        total++; if (s_err !== 24'd0) begin bad++; $display("FAIL clean_err got=%h exp=0", s_err); end
        total++; if (c_ts !== 16'd46) begin bad++; $display("FAIL clean_ts_cont got=%0d exp=46", c_ts); end
    endtask

    task automatic test_stop_on_fail();
        do_reset();
        arm = 1'b1;
        cyc(1);
        cyc(10);
        total++; if (s_state !== 2'd2 || s_ts !== 16'd0) begin bad++; $display("FAIL stop_enter state=%0d ts=%0d exp 2/0", s_state, s_ts); end
        cyc(5);
        check = golden ^ 3'b100;
        cyc(1);
        total++; if (s_fail !== 1'b1) begin bad++; $display("FAIL stop_fail got=%0b exp=1", s_fail); end
        total++; if (s_fc !== 2'd2) begin bad++; $display("FAIL stop_first_chan got=%0d exp=2", s_fc); end
        total++; if (s_fts !== 16'd5) begin bad++; $display("FAIL stop_first_ts got=%0d exp=5", s_fts); end
        total++; if (s_err[16 +: 8] !== 8'd1 || s_err[15:0] !== 16'd0) begin bad++; $display("FAIL stop_err got=%h exp=010000", s_err); end
        total++; if (s_state !== 2'd3 || s_mm !== 3'b100) begin bad++; $display("FAIL stop_halt state=%0d mm=%b exp 3/100", s_state, s_mm); end
        check = golden ^ 3'b011;
        cyc(5);
        total++; if (s_err !== 24'h010000 || s_ts !== 16'd6 || s_state !== 2'd3 || s_mm !== 3'b100) begin
            bad++; $display("FAIL stop_frozen err=%h ts=%0d state=%0d mm=%b exp 010000/6/3/100", s_err, s_ts, s_state, s_mm);
        end
        arm = 1'b0;
        cyc(1);
        total++; if (s_state !== 2'd0 || s_fail !== 1'b1 || s_fts !== 16'd5) begin
            bad++; $display("FAIL stop_disarm state=%0d fail=%0b fts=%0d exp 0/1/5", s_state, s_fail, s_fts);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        arm = 1'b1;
        cyc(1);
        cyc(4);
        golden = 3'b000;
        check  = 3'b110;
        cyc(300);
        total++; if (c_fc !== 2'd1 || c_fts !== 16'd0) begin bad++; $display("FAIL sat_first chan=%0d ts=%0d exp 1/0", c_fc, c_fts); end
        total++; if (c_err !== 24'hFFFF00) begin bad++; $display("FAIL sat_err got=%h exp=ffff00", c_err); end
        total++; if (c_state !== 2'd2 || c_fail !== 1'b1 || c_ts !== 16'd300) begin
            bad++; $display("FAIL sat_run state=%0d fail=%0b ts=%0d exp 2/1/300", c_state, c_fail, c_ts);
        end
    endtask

    task automatic test_settle_mask();
        do_reset();
        mask = 3'b001;
        arm  = 1'b1;
        cyc(1);
        golden = 3'b101;
        check  = 3'b010;
        cyc(10);
        check  = 3'b100;
        cyc(20);
        total++; if (s_fail !== 1'b0 || s_err !== 24'd0 || s_mm !== 3'd0) begin
            bad++; $display("FAIL mask_clean fail=%0b err=%h mm=%b exp 0/0/000", s_fail, s_err, s_mm);
        end
        total++; if (s_state !== 2'd2 || s_ts !== 16'd20) begin bad++; $display("FAIL mask_run state=%0d ts=%0d exp 2/20", s_state, s_ts); end
    endtask

    task automatic test_clock_en();
        do_reset();
        arm = 1'b1;
        cyc(1);
        for (int i = 0; i < 3; i++) begin
            clock_en = 1'b0; cyc(1);
            clock_en = 1'b1; cyc(1);
        end
        total++; if (c_state !== 2'd1) begin bad++; $display("FAIL ce_settle got=%0d exp=1", c_state); end
        clock_en = 1'b0; cyc(1);
        clock_en = 1'b1; cyc(1);
        total++; if (c_state !== 2'd2 || c_ts !== 16'd0) begin bad++; $display("FAIL ce_enter state=%0d ts=%0d exp 2/0", c_state, c_ts); end
        for (int i = 0; i < 6; i++) begin
            clock_en = 1'b0; cyc(1);
            clock_en = 1'b1; cyc(1);
        end
        total++; if (c_ts !== 16'd6) begin bad++; $display("FAIL ce_ts got=%0d exp=6", c_ts); end
        arm      = 1'b0;
        clock_en = 1'b0;
        check    = golden ^ 3'b001;
        cyc(1);
        total++; if (c_state !== 2'd2 || c_fail !== 1'b0 || c_ts !== 16'd6) begin
            bad++; $display("FAIL ce_hold state=%0d fail=%0b ts=%0d exp 2/0/6", c_state, c_fail, c_ts);
        end
        clock_en = 1'b1;
        cyc(1);
        total++; if (c_state !== 2'd0 || c_fail !== 1'b0 || c_err !== 24'd0 || c_ts !== 16'd6) begin
            bad++; $display("FAIL arm_priority state=%0d fail=%0b err=%h ts=%0d exp 0/0/0/6", c_state, c_fail, c_err, c_ts);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        arm = 1'b1;
        cyc(1);
        cyc(4);
        check = golden ^ 3'b001;
        cyc(3);
        total++; if (c_fail !== 1'b1 || c_err[7:0] !== 8'd3) begin bad++; $display("FAIL mid_pre fail=%0b err0=%0d exp 1/3", c_fail, c_err[7:0]); end
        reset = 1'b1;
        #1;
        total++; if (c_state !== 2'd0 || c_fail !== 1'b0 || c_err !== 24'd0 || c_ts !== 16'd0 || c_mm !== 3'd0 || c_fts !== 16'd0) begin
            bad++; $display("FAIL mid_async state=%0d fail=%0b err=%h ts=%0d mm=%b fts=%0d exp all 0", c_state, c_fail, c_err, c_ts, c_mm, c_fts);
        end
        reset = 1'b0;
        check = golden;
        cyc(1);
        cyc(10);
        total++; if (c_state !== 2'd2 || c_fail !== 1'b0 || c_ts !== 16'd6 || c_err !== 24'd0) begin
            bad++; $display("FAIL mid_rearm state=%0d fail=%0b ts=%0d err=%h exp 2/0/6/0", c_state, c_fail, c_ts, c_err);
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        clock_en = 1'b1;
        arm      = 1'b0;
        golden   = 3'b000;
        check    = 3'b000;
        mask     = 3'b000;
        cyc(2);
        test_reset();
        reset = 1'b0;
        test_clean();
        test_stop_on_fail();
        test_saturate();
        test_settle_mask();
        test_clock_en();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lockstep_compare.md
# lockstep_compare

Synthesizable lockstep monitor comparing CHANNELS output buses of a golden design against a design under check, sample by sample. It generalises the two-instance simulation comparison of the conversion tests into reusable RTL: parametrised channel count and width, a settle window after arming, per-channel mask, saturating mismatch counters, first-failure capture and a stop/continuous mode. It sits beside the two instances in a conversion-check top and drives a sticky pass/fail flag.

## Interface
- CHANNELS, 3, number of compared buses
- WIDTH, 1, bits per bus
- SETTLE, 10, qualified cycles ignored after arming before comparing (0 allowed)
- CNT_W, 8, per-channel mismatch counter width
- TS_W, 16, compare-cycle timestamp width
- STOP_ON_FAIL, 1, 1 = halt at first mismatch, 0 = keep counting
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- clock_en  in  1  sample qualifier; low cycles are ignored entirely
- arm  in  1  level; high enables checking, low returns to IDLE
- golden  in  CHANNELS*WIDTH  golden outputs, channel i at [i*WIDTH +: WIDTH]
- check  in  CHANNELS*WIDTH  outputs under check, same packing
- mask  in  CHANNELS  1 = channel excluded from comparison
- state  out  2  IDLE=0, SETTLE=1, COMPARE=2, HALT=3
- mismatch  out  CHANNELS  registered per-channel mismatch of last compared sample
- fail  out  1  sticky, set by any counted mismatch
- err_count  out  CHANNELS*CNT_W  saturating per-channel mismatch counts
- first_chan  out  clog2(CHANNELS) (min 1)  channel of first mismatch
- first_ts  out  TS_W  compare-cycle index of first mismatch
- ts  out  TS_W  number of compare cycles so far, saturating

## Operation
- Reset: state=IDLE, all outputs zero.
- IDLE: arm high (with clock_en) -> clear err_count, fail, mismatch, first_*, ts, settle counter; go SETTLE (or COMPARE if SETTLE=0).
- SETTLE: each clock_en cycle increments settle counter; after SETTLE such cycles -> COMPARE. No comparison.
- COMPARE: each clock_en cycle, for each unmasked channel, mismatch[i] = (golden_i != check_i); masked channel mismatch[i]=0. Any mismatch: increment err_count[i] (saturate at 2^CNT_W-1), set fail; if fail was 0, capture first_chan = lowest mismatching index, first_ts = ts. ts increments per compare cycle, saturating at 2^TS_W-1. If STOP_ON_FAIL and any mismatch -> HALT.
- HALT: all counters, flags, captures frozen; mismatch holds last value.
- arm low in any state (clock_en high) -> IDLE; results retained until next arming.
- X/Z on inputs compares as mismatch in simulation only; no special RTL handling.

## Timing
- All outputs registered; compare result for sample at edge N visible after edge N.
- clock_en low: no state, counter or output change, including arm deassertion.
- SETTLE=k: first compared sample is the (k+1)th qualified cycle after the arming cycle.
- Simultaneous mismatches on several channels: all counted; first_chan = lowest index.
- Mismatch in the same cycle arm falls: arm takes priority, sample not counted.
- reset mid-operation: immediate return to IDLE, all outputs zero.

## Structure
- Package lockstep_pkg: state enum typedef, state encodings, helper for clog2 with minimum 1.
- Sub-module lockstep_chan: one channel's compare, mask, saturating counter; generated CHANNELS times. Top holds FSM, settle counter, timestamp, first-failure priority encoder.

## Test plan
- CHANNELS=3, WIDTH=1, SETTLE=10: identical inputs 50 cycles after arm -> state=COMPARE, fail=0, ts=40, all err_count=0.
- Differ on channel 2 from compare cycle 5, STOP_ON_FAIL=1 -> fail=1, first_chan=2, first_ts=5, err_count[2]=1, state=HALT, frozen.
- STOP_ON_FAIL=0, channels 1 and 2 differ at same cycle for 300 cycles, CNT_W=8 -> first_chan=1, both counts saturate at 255.
- Mismatch during SETTLE only and on masked channel 0 -> fail=0, err_count=0.
- clock_en toggling every other cycle, SETTLE=4 -> compare starts after 4 qualified cycles; ts counts only enabled cycles.
- Assert reset during COMPARE with fail=1 -> all outputs 0, state=IDLE asynchronously; re-arm runs clean.
